// File: rtl/multi_fan_ctrl.sv
// Multi-channel fan controller: per-channel PI loop computed one channel per enabled
// cycle after a sample strobe, driving glitch-free PWM outputs from a shared counter.
module multi_fan_ctrl #(
  parameter int CHANNELS      = 2,
  parameter int ADC_BITWIDTH  = 4,
  parameter int FRAC_BITWIDTH = 6,
  parameter int PWM_PERIOD    = 19,
  parameter int MIN_DUTY      = 3
) (
  input  logic                                              clk_i,
  input  logic                                              rstn_i,
  input  logic                                              clk_en_i,
  input  logic [CHANNELS*ADC_BITWIDTH-1:0]                  adc_value_i,
  input  logic [ADC_BITWIDTH-1:0]                           set_value_i,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] set_ch_i,
  input  logic                                              config_en_i,
  input  logic                                              dataValid_STRB_i,
  input  logic [ADC_BITWIDTH+FRAC_BITWIDTH-1:0]             b2_i,
  input  logic [ADC_BITWIDTH+FRAC_BITWIDTH-1:0]             b0_i,
  output logic [CHANNELS-1:0]                               pwm_o,
  output logic                                              busy_o,
  output logic                                              done_o,
  output logic                                              overrun_o,
  output logic [1:0]                                        state_o
);

  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CW    = ADC_BITWIDTH + FRAC_BITWIDTH;
  localparam int EW    = ADC_BITWIDTH + 1;
  localparam int SW    = CW + EW + 2;
  localparam int CNT_W = $clog2(PWM_PERIOD + 1);
  localparam logic [CW-1:0]           Y_MAX     = CW'(((2 ** ADC_BITWIDTH) - 1) << FRAC_BITWIDTH);
  localparam logic signed [SW-1:0]    Y_MAX_EXT = SW'(Y_MAX);
  localparam logic [ADC_BITWIDTH-1:0] MIN_D     = ADC_BITWIDTH'(MIN_DUTY);
  localparam logic [CNT_W-1:0]        CNT_MAX   = CNT_W'(PWM_PERIOD);
  localparam logic [IDX_W-1:0]        LAST_CH   = IDX_W'(CHANNELS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, CONFIG = 2'd2} state_t;

  state_t state_reg, state_next;
  logic [IDX_W-1:0] ch_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             done_reg, overrun_reg;

  logic start_calc, calc_step, last_ch, wrap;
  assign start_calc = clk_en_i && (state_reg == IDLE) && !config_en_i && dataValid_STRB_i;
  assign calc_step  = clk_en_i && (state_reg == CALC);
  assign last_ch    = (ch_reg == LAST_CH);
  assign wrap       = clk_en_i && (cnt_reg == CNT_MAX);

  // Per-channel state lives in the generate scope; these arrays expose it to the shared datapath.
  logic [ADC_BITWIDTH-1:0] setpoint_arr [CHANNELS];
  logic [ADC_BITWIDTH-1:0] sample_arr   [CHANNELS];
  logic [CW-1:0]           y_arr        [CHANNELS];
  logic signed [EW-1:0]    e_arr        [CHANNELS];

  logic signed [EW-1:0]    e_new;
  logic signed [SW-1:0]    y_ext, prod2, prod0, y_sum;
  logic [CW-1:0]           y_sat;
  logic [ADC_BITWIDTH-1:0] duty_raw, duty_new;

  assign e_new    = $signed({1'b0, setpoint_arr[ch_reg]}) - $signed({1'b0, sample_arr[ch_reg]});
  assign y_ext    = SW'($signed({1'b0, y_arr[ch_reg]}));
  assign prod2    = SW'($signed(b2_i)) * SW'(e_new);
  assign prod0    = SW'($signed(b0_i)) * SW'(e_arr[ch_reg]);
  assign y_sum    = y_ext + prod2 + prod0;
  assign duty_raw = y_sat[CW-1:FRAC_BITWIDTH];
  assign duty_new = ((duty_raw != '0) && (duty_raw < MIN_D)) ? MIN_D : duty_raw;

  // Clamping the stored integrator is the anti-windup: y never leaves the usable duty range.
  always_comb begin
    y_sat = y_sum[CW-1:0];
    if (y_sum[SW-1])
      y_sat = '0;
    else if (y_sum > Y_MAX_EXT)
      y_sat = Y_MAX;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (clk_en_i) begin
      case (state_reg)
        IDLE:    if (config_en_i) state_next = CONFIG;
                 else if (dataValid_STRB_i) state_next = CALC;
        CALC:    if (last_ch) state_next = IDLE;
        CONFIG:  if (!config_en_i) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o  = (state_reg == CALC);
    state_o = state_reg;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ch_reg      <= '0;
      cnt_reg     <= '0;
      done_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      // done is a single clk_i pulse regardless of the enable pattern that follows.
      done_reg <= calc_step && last_ch;
      if (calc_step && dataValid_STRB_i)
        overrun_reg <= 1'b1;
      if (start_calc)
        ch_reg <= '0;
      else if (calc_step)
        ch_reg <= ch_reg + 1'b1;
      if (wrap)
        cnt_reg <= '0;
      else if (clk_en_i)
        cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign done_o    = done_reg;
  assign overrun_o = overrun_reg;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [ADC_BITWIDTH-1:0] setpoint_reg, sample_reg, pend_duty_reg, act_duty_reg;
      logic [CW-1:0]           y_reg;
      logic signed [EW-1:0]    e_reg;
      logic                    sel;

      assign sel = calc_step && (ch_reg == IDX_W'(gi));

      always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
          setpoint_reg  <= '0;
          sample_reg    <= '0;
          pend_duty_reg <= '0;
          act_duty_reg  <= '0;
          y_reg         <= '0;
          e_reg         <= '0;
        end else begin
          if (clk_en_i && (state_reg == CONFIG) && dataValid_STRB_i && (set_ch_i == IDX_W'(gi)))
            setpoint_reg <= set_value_i;
          if (start_calc)
            sample_reg <= adc_value_i[gi*ADC_BITWIDTH +: ADC_BITWIDTH];
          if (sel) begin
            y_reg         <= y_sat;
            e_reg         <= e_new;
            pend_duty_reg <= duty_new;
          end
          if (wrap)
            act_duty_reg <= pend_duty_reg;
        end
      end

      assign setpoint_arr[gi] = setpoint_reg;
      assign sample_arr[gi]   = sample_reg;
      assign y_arr[gi]        = y_reg;
      assign e_arr[gi]        = e_reg;
      assign pwm_o[gi]        = (cnt_reg < CNT_W'(act_duty_reg));
    end
  endgenerate

endmodule

// File: tb/tb_multi_fan_ctrl.sv
// Bench for multi_fan_ctrl: directed scenarios plus randomized traffic, all checked
// every cycle against an integer-arithmetic reference model of the controller.
module tb_multi_fan_ctrl;
  localparam int CH = 2;
  localparam int PERIOD = 20;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       clk_en = 1'b0;
  logic [7:0] adc = '0;
  logic [3:0] set_v = '0;
  logic [0:0] set_ch = '0;
  logic       cfg = 1'b0;
  logic       strobe = 1'b0;
  logic [9:0] b2 = '0;
  logic [9:0] b0 = '0;
  logic [1:0] pwm;
  logic       busy, done, ovr;
  logic [1:0] state;

  int total = 0;
  int bad = 0;
  int div = 1;

  always #5 clk = ~clk;

  multi_fan_ctrl dut (
    .clk_i(clk), .rstn_i(rstn), .clk_en_i(clk_en), .adc_value_i(adc),
    .set_value_i(set_v), .set_ch_i(set_ch), .config_en_i(cfg),
    .dataValid_STRB_i(strobe), .b2_i(b2), .b0_i(b0), .pwm_o(pwm),
    .busy_o(busy), .done_o(done), .overrun_o(ovr), .state_o(state)
  );

  // Reference model: 0 = run/idle, 1 = calculating, 2 = configuring.
  int m_state, m_ch, m_cnt, m_txn;
  int m_sp[CH], m_smp[CH], m_y[CH], m_e[CH], m_pend[CH], m_act[CH];
  int m_done, m_ovr;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int duty_of(input int y);
    int d;
    d = y / 64;
    if (d > 0 && d < 3) d = 3;
    return d;
  endfunction

  task automatic model_reset();
    m_state = 0; m_ch = 0; m_cnt = 0; m_done = 0; m_ovr = 0;
    for (int n = 0; n < CH; n++) begin
      m_sp[n] = 0; m_smp[n] = 0; m_y[n] = 0; m_e[n] = 0; m_pend[n] = 0; m_act[n] = 0;
    end
  endtask

  task automatic model_edge();
    int b2v, b0v, en, yn;
    m_done = 0;
    if (!clk_en) return;
    if (m_cnt == PERIOD - 1) begin
      m_cnt = 0;
      for (int n = 0; n < CH; n++) m_act[n] = m_pend[n];
    end else begin
      m_cnt++;
    end
    case (m_state)
      0: begin
        if (cfg) m_state = 2;
        else if (strobe) begin
          m_state = 1;
          m_ch = 0;
          for (int n = 0; n < CH; n++) m_smp[n] = (int'(adc) >> (4 * n)) & 15;
        end
      end
      2: begin
        if (strobe && int'(set_ch) < CH) m_sp[set_ch] = int'(set_v);
        if (!cfg) m_state = 0;
      end
      default: begin
        if (strobe) m_ovr = 1;
        b2v = $signed(b2);
        b0v = $signed(b0);
        en = m_sp[m_ch] - m_smp[m_ch];
        yn = m_y[m_ch] + b2v * en + b0v * m_e[m_ch];
        if (yn < 0) yn = 0;
        if (yn > 15 * 64) yn = 15 * 64;
        m_y[m_ch] = yn;
        m_e[m_ch] = en;
        m_pend[m_ch] = duty_of(yn);
        m_ch++;
        if (m_ch == CH) begin
          m_state = 0;
          m_done = 1;
          m_txn++;
          $display("txn %0d duty0=%0d duty1=%0d y0=%0d y1=%0d", m_txn, m_pend[0], m_pend[1], m_y[0], m_y[1]);
        end
      end
    endcase
  endtask

  task automatic compare();
    for (int n = 0; n < CH; n++)
      check($sformatf("pwm%0d", n), int'(pwm[n]), (m_cnt < m_act[n]) ? 1 : 0);
    check("state", int'(state), m_state);
    check("busy", int'(busy), (m_state == 1) ? 1 : 0);
    check("done", int'(done), m_done);
    check("overrun", int'(ovr), m_ovr);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rstn) model_edge();
    #1;
    compare();
  endtask

  task automatic ecycles(input int n);
    repeat (n) begin
      for (int k = 0; k < div; k++) begin
        clk_en = (k == div - 1);
        tick();
      end
    end
  endtask

  task automatic hi_count(input int n_en, output int h0, output int h1);
    h0 = 0; h1 = 0;
    repeat (n_en) begin
      for (int k = 0; k < div; k++) begin
        clk_en = (k == div - 1);
        tick();
        h0 += int'(pwm[0]);
        h1 += int'(pwm[1]);
      end
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    model_reset();
    #1;
    check("rst_pwm", int'(pwm), 0);
    check("rst_state", int'(state), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_overrun", int'(ovr), 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic setup(input int sp0, input int sp1);
    cfg = 1'b1; strobe = 1'b0;
    ecycles(1);
    strobe = 1'b1; set_ch = 1'b0; set_v = 4'(sp0);
    ecycles(1);
    set_ch = 1'b1; set_v = 4'(sp1);
    ecycles(1);
    strobe = 1'b0; cfg = 1'b0;
    ecycles(1);
  endtask

  task automatic run(input int a0, input int a1);
    adc = {4'(a1), 4'(a0)};
    strobe = 1'b1;
    ecycles(1);
    strobe = 1'b0;
    ecycles(CH + 1);
  endtask

  initial begin
    int h0, h1, dn, v;
    model_reset();
    m_txn = 0;
    do_reset();

    // setpoint 10 vs sample 4 gives duty 6; setpoint 15 vs 0 saturates at duty 15
    b2 = 10'd64; b0 = 10'd0;
    setup(10, 15);
    run(4, 0);
    ecycles(25);
    hi_count(40, h0, h1);
    check("duty6_hi", h0, 12);
    check("duty15_hi", h1, 30);
    run(4, 0);
    ecycles(25);
    hi_count(40, h0, h1);
    check("accum_hi", h0, 24);
    check("clamp_hi", h1, 30);

    // minimum-duty forcing and negative-error clamp to zero
    do_reset();
    setup(1, 0);
    run(0, 5);
    ecycles(25);
    hi_count(40, h0, h1);
    check("min_duty_hi", h0, 6);
    check("zero_duty_hi", h1, 0);

    // strobe while calculating
    strobe = 1'b1;
    ecycles(1);
    ecycles(1);
    dn = int'(done);
    strobe = 1'b0;
    repeat (9) begin
      ecycles(1);
      dn += int'(done);
    end
    check("done_once", dn, 1);
    check("overrun_set", int'(ovr), 1);

    // enable asserted one cycle in four
    do_reset();
    div = 4;
    setup(10, 15);
    run(4, 0);
    ecycles(25);
    hi_count(40, h0, h1);
    check("slow_hi0", h0, 4 * 12);
    check("slow_hi1", h1, 4 * 30);
    div = 1;

    // reset in the middle of a calculation
    do_reset();
    setup(10, 15);
    adc = {4'd0, 4'd4};
    strobe = 1'b1;
    ecycles(1);
    strobe = 1'b0;
    ecycles(1);
    do_reset();
    setup(10, 15);
    run(4, 0);
    ecycles(25);
    hi_count(40, h0, h1);
    check("post_rst_hi0", h0, 12);
    check("post_rst_hi1", h1, 30);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      clk_en = ($urandom_range(0, 3) != 0);
      strobe = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 30) == 0) cfg = ~cfg;
      adc = 8'($urandom);
      set_v = 4'($urandom);
      set_ch = 1'($urandom);
      if ($urandom_range(0, 60) == 0) begin
        v = int'($urandom_range(0, 160));
        b2 = 10'(v);
        v = int'($urandom_range(0, 192)) - 96;
        b0 = 10'(v);
      end
      tick();
      if ($urandom_range(0, 700) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
